key_reg_reader: RTL and testbench
=================================

Name: key_reg_reader

Overview:
- Read-side controller for the serial key-register chain, which is loaded word-by-word through its shift input.
- Drives the chain's enable and shift-select to rotate the chain one word per accepted output beat.
- Presents each tail word on a valid/ready output stream.
- Feeds the tail back into the chain head, so after WORDS beats the key state is restored unchanged and the next round-key schedule can run.

Parameters:
- WIDTH, 32, word width of one chain stage and of the output stream.
- WORDS, 4, number of stages in the chain (beats per readout), WORDS >= 2.
- CW, 3, counter width, must satisfy 2^CW > WORDS.

Ports:
- clk, input, 1, system clock, all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, request one full readout; sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse after the last beat is accepted.
- kr_so, input, WIDTH, tail word of the key chain (output of the last stage).
- kr_si, output, WIDTH, head input of the key chain; always equals kr_so (rotation feedback).
- kr_enc, output, 1, chain clock-enable.
- kr_se, output, 1, chain shift-select (1 = shift si, 0 = schedule update).
- odata, output, WIDTH, output word.
- ovalid, output, 1, odata valid.
- oready, input, 1, downstream accepts odata.
- beat, output, CW, index of the current beat (0 = first word out).

Behaviour:
- States: IDLE, READ, DONE. Reset forces IDLE and beat=0.
- Reset values: busy=0, done=0, ovalid=0, kr_enc=0, kr_se=0.
- IDLE:
  - start=1 -> READ next cycle, beat=0.
  - Otherwise hold; kr_enc=0.
- READ:
  - busy=1, ovalid=1, odata=kr_so (combinational, zero added latency), kr_se=1.
  - kr_enc = ovalid & oready, so the chain shifts exactly once per accepted beat and never while stalled.
  - On a handshake with beat < WORDS-1: beat increments.
  - On a handshake with beat = WORDS-1: move to DONE, beat cleared to 0.
  - oready low: odata, beat and chain all hold; odata stays stable while valid.
- DONE:
  - done=1 for exactly one cycle, busy=1, ovalid=0, kr_enc=0.
  - Next state is IDLE.
- start while busy: ignored, never queued.
- start held high continuously: a new readout begins in the cycle after the IDLE cycle that follows DONE. Minimum gap between readouts is one IDLE cycle.
- kr_se is 0 outside READ, so the chain's schedule path remains selectable by the owning datapath when kr_enc is driven elsewhere. This block drives kr_enc only in READ.
- Invariant: the number of chain shifts during a readout equals WORDS, so the chain content after DONE equals the content before start.
- Reset mid-READ: outputs return to reset values immediately (async). The chain is left partially rotated by beat positions; the key must be reloaded by the owner. No recovery is attempted.
- kr_si = kr_so is unconditional and purely combinational.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, READ=2'd1, DONE=2'd2);
  - default WIDTH/WORDS values shared with the key-register chain instantiation.
- No sub-module: the beat counter and FSM sit in one module. The chain itself stays outside, in the existing key-register instances.

Test Plan:
- Basic readout: chain (head->tail) = 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233; start pulse, oready=1 -> odata sequence 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles, done pulses on the next cycle, chain equals its initial value.
- Backpressure: same load, oready low for 3 cycles after beat 1 -> odata holds 0x44556677, kr_enc=0 and beat=1 throughout the stall; sequence and final chain content unchanged.
- start during READ/DONE: extra start pulses at beat 2 and in DONE -> no effect, exactly 4 beats and one done pulse.
- start held high: two back-to-back readouts, each 4 beats, separated by exactly one IDLE cycle with ovalid=0; chain restored after each.
- Async reset at beat 2: rst low mid-cycle -> ovalid, busy, kr_enc drop immediately; after release the block is in IDLE with beat=0 and the chain rotated by 2 words (tail = 0x8899AABB).
- Reset idle values: rst low with oready=1, start=1 -> all outputs 0, no chain enable.

Source files
------------

// File: rtl/key_reg_reader_pkg.sv
// Shared definitions for the key-register chain readout controller.
// Default sizes match the key-register chain instantiation.
package key_reg_reader_pkg;

    localparam int KR_WIDTH = 32;
    localparam int KR_WORDS = 4;
    localparam int KR_CW    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/key_reg_reader.sv
// Rotates the serial key chain one word per accepted beat, streaming the tail.
// Tail is fed back to the head so WORDS beats leave the key unchanged.
module key_reg_reader
    import key_reg_reader_pkg::*;
#(
    parameter int WIDTH = KR_WIDTH,
    parameter int WORDS = KR_WORDS,
    parameter int CW    = KR_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [WIDTH-1:0] kr_so,
    output logic [WIDTH-1:0] kr_si,
    output logic             kr_enc,
    output logic             kr_se,
    output logic [WIDTH-1:0] odata,
    output logic             ovalid,
    input  logic             oready,
    output logic [CW-1:0]    beat
);

    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        busy    = 1'b0;
        done    = 1'b0;
        ovalid  = 1'b0;
        kr_enc  = 1'b0;
        kr_se   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    beat_d  = '0;
                end
            end
            READ: begin
                busy   = 1'b1;
                ovalid = 1'b1;
                kr_se  = 1'b1;
                // Chain moves only on an accepted beat
                kr_enc = oready;
                if (oready) begin
                    if (beat_q == LAST) begin
                        state_d = DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    assign kr_si = kr_so;
    assign odata = ovalid ? kr_so : '0;
    assign beat  = beat_q;

endmodule

// File: tb/tb_key_reg_reader.sv
// Directed bench for key_reg_reader with a behavioural 4-word key chain.
module tb_key_reg_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] kr_so;
    logic [31:0] kr_si;
    logic        kr_enc;
    logic        kr_se;
    logic [31:0] odata;
    logic        ovalid;
    logic        oready;
    logic [2:0]  beat;

    logic        load_req;
    logic [31:0] chain    [4];
    logic [31:0] load_val [4];
    logic [31:0] exp_w    [4];

    int checks;
    int errors;

    key_reg_reader #(.WIDTH(32), .WORDS(4), .CW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .kr_so  (kr_so),
        .kr_si  (kr_si),
        .kr_enc (kr_enc),
        .kr_se  (kr_se),
        .odata  (odata),
        .ovalid (ovalid),
        .oready (oready),
        .beat   (beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: index 0 is the head, index 3 the tail
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 4; i++) chain[i] <= load_val[i];
        end else if (kr_enc) begin
            chain[0] <= kr_si;
            for (int i = 1; i < 4; i++) chain[i] <= chain[i-1];
        end
    end

    assign kr_so = chain[3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat_ok(input int i);
        chk("beat", 32'(beat), 32'(i));
        chk("odata", odata, exp_w[i]);
        chk("kr_si", kr_si, exp_w[i]);
        chk("ovalid", 32'(ovalid), 32'd1);
        chk("kr_enc", 32'(kr_enc), 32'(oready));
        chk("kr_se", 32'(kr_se), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        chk("done", 32'(done), 32'd0);
    endtask

    task automatic done_ok;
        chk("d_done", 32'(done), 32'd1);
        chk("d_busy", 32'(busy), 32'd1);
        chk("d_ovalid", 32'(ovalid), 32'd0);
        chk("d_kr_enc", 32'(kr_enc), 32'd0);
        chk("d_kr_se", 32'(kr_se), 32'd0);
        chk("d_beat", 32'(beat), 32'd0);
    endtask

    task automatic idle_ok;
        chk("i_done", 32'(done), 32'd0);
        chk("i_busy", 32'(busy), 32'd0);
        chk("i_ovalid", 32'(ovalid), 32'd0);
        chk("i_kr_enc", 32'(kr_enc), 32'd0);
        chk("i_kr_se", 32'(kr_se), 32'd0);
        chk("i_beat", 32'(beat), 32'd0);
    endtask

    task automatic chain_ok;
        for (int i = 0; i < 4; i++) chk("chain", chain[i], load_val[i]);
    endtask

    task automatic rst_outs_ok;
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_done", 32'(done), 32'd0);
        chk("r_ovalid", 32'(ovalid), 32'd0);
        chk("r_kr_enc", 32'(kr_enc), 32'd0);
        chk("r_kr_se", 32'(kr_se), 32'd0);
        chk("r_beat", 32'(beat), 32'd0);
        chk("r_odata", odata, 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        load_val[0] = 32'hCCDDEEFF;
        load_val[1] = 32'h8899AABB;
        load_val[2] = 32'h44556677;
        load_val[3] = 32'h00112233;
        exp_w[0]    = 32'h00112233;
        exp_w[1]    = 32'h44556677;
        exp_w[2]    = 32'h8899AABB;
        exp_w[3]    = 32'hCCDDEEFF;
        for (int i = 0; i < 4; i++) chain[i] = 32'h0;

        // Reset with start and oready asserted
        rst      = 1'b0;
        start    = 1'b1;
        oready   = 1'b1;
        load_req = 1'b0;
        #2;
        rst_outs_ok();
        tick();
        rst_outs_ok();

        rst      = 1'b1;
        start    = 1'b0;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        #1;
        chk("loaded_tail", kr_so, 32'h00112233);
        idle_ok();

        // Basic readout
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            beat_ok(i);
            tick();
        end
        done_ok();
        tick();
        idle_ok();
        chain_ok();

        // Backpressure after beat 1
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        beat_ok(0);
        tick();
        oready = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("stall_odata", odata, 32'h44556677);
            chk("stall_beat", 32'(beat), 32'd1);
            chk("stall_enc", 32'(kr_enc), 32'd0);
            chk("stall_valid", 32'(ovalid), 32'd1);
            tick();
        end
        oready = 1'b1;
        #1;
        for (int i = 1; i < 4; i++) begin
            beat_ok(i);
            tick();
        end
        done_ok();
        tick();
        idle_ok();
        chain_ok();

        // start pulses during READ and DONE are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        beat_ok(0);
        tick();
        beat_ok(1);
        tick();
        start = 1'b1;
        #1;
        beat_ok(2);
        tick();
        start = 1'b0;
        #1;
        beat_ok(3);
        tick();
        start = 1'b1;
        #1;
        done_ok();
        tick();
        start = 1'b0;
        #1;
        idle_ok();
        tick();
        idle_ok();
        chain_ok();

        // start held high: back-to-back readouts with one IDLE gap
        start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            beat_ok(i);
            tick();
        end
        done_ok();
        tick();
        idle_ok();
        chain_ok();
        tick();
        beat_ok(0);
        start = 1'b0;
        tick();
        for (int i = 1; i < 4; i++) begin
            beat_ok(i);
            tick();
        end
        done_ok();
        tick();
        idle_ok();
        tick();
        idle_ok();
        chain_ok();

        // Asynchronous reset at beat 2
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        beat_ok(0);
        tick();
        beat_ok(1);
        tick();
        beat_ok(2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_ovalid", 32'(ovalid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_kr_enc", 32'(kr_enc), 32'd0);
        chk("ar_beat", 32'(beat), 32'd0);
        tick();
        chk("ar_tail", kr_so, 32'h8899AABB);
        rst = 1'b1;
        tick();
        idle_ok();
        chk("ar_tail2", kr_so, 32'h8899AABB);

        // Reset idle values with start and oready high
        rst    = 1'b0;
        start  = 1'b1;
        oready = 1'b1;
        #1;
        rst_outs_ok();
        tick();
        rst_outs_ok();
        chk("rst_tail", kr_so, 32'h8899AABB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
